// File: rtl/dma_axi_addr_issuer_pkg.sv
// Shared DMA utilities: AXI address-request payload, burst/response constants
// and the issue-stage state encoding.
package dma_axi_addr_issuer_pkg;

  localparam int          DMA_AXI_ADDR_MAX     = 64;
  localparam logic [1:0]  DMA_AXI_BURST_INCR   = 2'b01;
  localparam int          DMA_AXI_RESP_ERR_BIT = 1;

  // Address field sized for the widest supported bus; narrower users zero-extend.
  typedef struct packed {
    logic [DMA_AXI_ADDR_MAX-1:0] addr;
    logic [7:0]                  alen;
    logic [2:0]                  size;
  } s_dma_axi_addr_req_t;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_PRESENT
  } e_issue_state_t;

endpackage

// File: rtl/dma_fifo_sync.sv
// Synchronous FIFO, registered flags, one-cycle flush; push+pop while full keeps occupancy.
// Pushes while full without a pop are dropped; pops while empty are ignored.
module dma_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dma_axi_addr_issuer.sv
// AXI AR/AW issue stage: queues streamer bursts, presents one at a time (valid 1 cycle after accept),
// caps outstanding bursts and tracks completions; req_ready_o drops when the queue is full or on abort.
module dma_axi_addr_issuer
  import dma_axi_addr_issuer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int TXN_ID          = 0,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]            req_alen_i,
  input  logic [2:0]            req_size_i,
  input  logic                  abort_i,
  output logic                  axi_valid_o,
  input  logic                  axi_ready_i,
  output logic [ADDR_WIDTH-1:0] axi_addr_o,
  output logic [7:0]            axi_len_o,
  output logic [2:0]            axi_size_o,
  output logic [1:0]            axi_burst_o,
  output logic [ID_WIDTH-1:0]   axi_id_o,
  input  logic                  resp_valid_i,
  input  logic                  resp_err_i,
  input  logic                  clear_i,
  output logic                  pend_txn_o,
  output logic                  txn_err_o
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  s_dma_axi_addr_req_t req_in, fifo_head, pres_q, pres_d;
  e_issue_state_t      state_q, state_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                req_fire, addr_hs, src_avail, load;
  logic                underflow, resp_dec;
  logic                unused_addr_hi;

  assign req_ready_o = !rst && !fifo_full && !abort_i;
  assign req_fire    = req_valid_i && req_ready_o;
  assign addr_hs     = (state_q == ISSUE_PRESENT) && axi_ready_i;

  always_comb begin
    req_in                        = '0;
    req_in.addr[ADDR_WIDTH-1:0]   = req_addr_i;
    req_in.alen                   = req_alen_i;
    req_in.size                   = req_size_i;
  end

  dma_fifo_sync #(
    .WIDTH ($bits(s_dma_axi_addr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (abort_i),
    .push_i  (fifo_push),
    .wdata_i (req_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A response with nothing outstanding is flagged and otherwise discarded.
  always_comb begin
    underflow = resp_valid_i && (out_cnt_q == '0);
    resp_dec  = resp_valid_i && !underflow;
    out_cnt_d = out_cnt_q;
    case ({addr_hs, resp_dec})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Issue decisions look at next cycle's count, so a slot freed by a response
  // shows up as a presented burst one cycle later. An empty queue is bypassed
  // so a fresh request reaches the bus one cycle after acceptance.
  always_comb begin
    src_avail = !fifo_empty || req_fire;
    load      = !abort_i && src_avail && (out_cnt_d < CNT_MAX)
                && ((state_q == ISSUE_IDLE) || addr_hs);
    fifo_pop  = load && !fifo_empty;
    fifo_push = req_fire && !(load && fifo_empty);

    state_d = state_q;
    pres_d  = pres_q;
    case (state_q)
      ISSUE_IDLE: begin
        if (load) state_d = ISSUE_PRESENT;
      end
      ISSUE_PRESENT: begin
        if (addr_hs) state_d = load ? ISSUE_PRESENT : ISSUE_IDLE;
      end
      default: state_d = ISSUE_IDLE;
    endcase
    if (load) pres_d = fifo_empty ? req_in : fifo_head;
  end

  always_comb begin
    pend_d = req_fire || (!fifo_empty && !abort_i)
             || (state_d == ISSUE_PRESENT) || (out_cnt_d != '0);
    err_d  = err_q;
    if (clear_i) err_d = 1'b0;
    if (resp_valid_i && (resp_err_i || underflow)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ISSUE_IDLE;
      pres_q    <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pres_q    <= pres_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  assign axi_valid_o    = (state_q == ISSUE_PRESENT);
  assign axi_addr_o     = pres_q.addr[ADDR_WIDTH-1:0];
  assign axi_len_o      = pres_q.alen;
  assign axi_size_o     = pres_q.size;
  assign axi_burst_o    = DMA_AXI_BURST_INCR;
  assign axi_id_o       = ID_WIDTH'(TXN_ID);
  assign pend_txn_o     = pend_q;
  assign txn_err_o      = err_q;
  assign unused_addr_hi = ^pres_q.addr;

endmodule

// File: tb/tb_dma_axi_addr_issuer.sv
// Directed bench for dma_axi_addr_issuer: a vector table for single-burst and
// error behaviour, plus sequences for backpressure, outstanding cap, abort and reset.
module tb_dma_axi_addr_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [7:0]  req_alen;
  logic [2:0]  req_size;
  logic        abort;
  logic        axi_ready;
  logic        resp_valid;
  logic        resp_err;
  logic        clear;

  logic        rdy, vld, pend, err;
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [7:0]  id;

  logic        c_vld;
  logic [31:0] c_addr;
  logic        c_unused_rdy, c_unused_pend, c_unused_err;
  logic [7:0]  c_unused_len, c_unused_id;
  logic [2:0]  c_unused_size;
  logic [1:0]  c_unused_burst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_axi_addr_issuer #(.MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(rdy), .req_addr_i(req_addr),
    .req_alen_i(req_alen), .req_size_i(req_size), .abort_i(abort),
    .axi_valid_o(vld), .axi_ready_i(axi_ready), .axi_addr_o(addr),
    .axi_len_o(len), .axi_size_o(size), .axi_burst_o(burst), .axi_id_o(id),
    .resp_valid_i(resp_valid), .resp_err_i(resp_err), .clear_i(clear),
    .pend_txn_o(pend), .txn_err_o(err)
  );

  dma_axi_addr_issuer #(.MAX_OUTSTANDING(2)) u_cap (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(c_unused_rdy), .req_addr_i(req_addr),
    .req_alen_i(req_alen), .req_size_i(req_size), .abort_i(abort),
    .axi_valid_o(c_vld), .axi_ready_i(axi_ready), .axi_addr_o(c_addr),
    .axi_len_o(c_unused_len), .axi_size_o(c_unused_size), .axi_burst_o(c_unused_burst),
    .axi_id_o(c_unused_id),
    .resp_valid_i(resp_valid), .resp_err_i(resp_err), .clear_i(clear),
    .pend_txn_o(c_unused_pend), .txn_err_o(c_unused_err)
  );

  typedef struct {
    logic        rv;
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic        ar, pv, pe, clr;
    logic        e_rdy, e_vld;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [2:0]  e_size;
    logic        e_pend, e_err;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic rv, input logic [31:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic ar, input logic pv,
                              input logic pe, input logic clr, input logic e_rdy,
                              input logic e_vld, input logic [31:0] e_addr,
                              input logic [7:0] e_len, input logic [2:0] e_size,
                              input logic e_pend, input logic e_err);
    vec_t v;
    v.rv = rv; v.a = a; v.l = l; v.s = s; v.ar = ar; v.pv = pv; v.pe = pe; v.clr = clr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_addr = e_addr; v.e_len = e_len;
    v.e_size = e_size; v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic ar, input logic pv,
                       input logic pe, input logic clr, input logic ab);
    req_valid = rv; req_addr = a; req_alen = l; req_size = s;
    axi_ready = ar; resp_valid = pv; resp_err = pe; clear = clr; abort = ab;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk("rst_rdy_low", rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld", vld, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", addr, 0);
    chk("rst_len", len, 0);
    chk("rst_size", size, 0);
    chk("rst_rdy_high", rdy, 1);
    chk("rst_cap_vld", c_vld, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rv a         l  s  ar pv pe clr| rdy vld e_addr    el es pend err
    tbl[0]  = mk(1, 32'h1000, 7, 2, 1, 0, 0, 0,   1, 0, 32'h0,    0, 0, 0, 0);
    tbl[1]  = mk(0, 32'h0,    0, 0, 1, 0, 0, 0,   1, 1, 32'h1000, 7, 2, 1, 0);
    tbl[2]  = mk(0, 32'h0,    0, 0, 1, 0, 0, 0,   1, 0, 32'h0,    0, 0, 1, 0);
    tbl[3]  = mk(0, 32'h0,    0, 0, 0, 0, 0, 0,   1, 0, 32'h0,    0, 0, 1, 0);
    tbl[4]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0,   1, 0, 32'h0,    0, 0, 1, 0);
    tbl[5]  = mk(0, 32'h0,    0, 0, 0, 0, 0, 0,   1, 0, 32'h0,    0, 0, 0, 0);
    tbl[6]  = mk(0, 32'h0,    0, 0, 0, 1, 0, 0,   1, 0, 32'h0,    0, 0, 0, 0);
    tbl[7]  = mk(0, 32'h0,    0, 0, 0, 0, 0, 1,   1, 0, 32'h0,    0, 0, 0, 1);
    tbl[8]  = mk(1, 32'h2000, 3, 3, 1, 0, 0, 0,   1, 0, 32'h0,    0, 0, 0, 0);
    tbl[9]  = mk(0, 32'h0,    0, 0, 1, 0, 0, 0,   1, 1, 32'h2000, 3, 3, 1, 0);
    tbl[10] = mk(0, 32'h0,    0, 0, 0, 1, 1, 0,   1, 0, 32'h0,    0, 0, 1, 0);
    tbl[11] = mk(0, 32'h0,    0, 0, 0, 1, 1, 1,   1, 0, 32'h0,    0, 0, 0, 1);
    tbl[12] = mk(0, 32'h0,    0, 0, 0, 0, 0, 1,   1, 0, 32'h0,    0, 0, 0, 1);
    tbl[13] = mk(0, 32'h0,    0, 0, 0, 0, 0, 0,   1, 0, 32'h0,    0, 0, 0, 0);

    @(negedge clk);
    reset_dut();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].rv, tbl[i].a, tbl[i].l, tbl[i].s, tbl[i].ar, tbl[i].pv,
            tbl[i].pe, tbl[i].clr, 0);
      #1;
      chk($sformatf("v%0d_rdy", i), rdy, tbl[i].e_rdy);
      chk($sformatf("v%0d_vld", i), vld, tbl[i].e_vld);
      chk($sformatf("v%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("v%0d_burst", i), burst, 2'b01);
      chk($sformatf("v%0d_id", i), id, 8'h00);
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_addr", i), addr, tbl[i].e_addr);
        chk($sformatf("v%0d_len", i), len, tbl[i].e_len);
        chk($sformatf("v%0d_size", i), size, tbl[i].e_size);
      end
    end

    // Backpressure: one presented + four queued fills the queue.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 32'h100 * (i + 1), 8'(i), 3'd1, 0, 0, 0, 0, 0);
      #1 chk("bp_rdy_open", rdy, 1);
    end
    @(negedge clk);
    drive(1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("bp_rdy_full", rdy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("bp_hold_vld", vld, 1);
      chk("bp_hold_addr", addr, 32'h100);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1;
      chk("bp_drain_vld", vld, 1);
      chk("bp_drain_addr", addr, 32'h100 * (i + 1));
      chk("bp_drain_len", len, 8'(i));
    end
    @(negedge clk);
    #1 chk("bp_done_vld", vld, 0);

    // Outstanding cap of two on u_cap.
    reset_dut();
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 4) drive(1, 32'h4000 + 32'h40 * i, 0, 0, 1, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1 if (c_vld && axi_ready) hs++;
    end
    chk("cap_handshakes", hs, 2);
    chk("cap_stalled", c_vld, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    #1 chk("cap_resp_cycle_vld", c_vld, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("cap_third_vld", c_vld, 1);
    chk("cap_third_addr", c_addr, 32'h4080);

    // Abort with one presented and three queued.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 32'h8000 + 32'h10 * i, 0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("abort_rdy", rdy, 0);
    chk("abort_vld_kept", vld, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("abort_hs_vld", vld, 1);
    chk("abort_hs_addr", addr, 32'h8000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("abort_flushed_vld", vld, 0);
      chk("abort_pend_held", pend, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("abort_pend_at_resp", pend, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("abort_pend_after", pend, 0);

    // Reset with bursts queued, presented, outstanding and an error set.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 32'hA000 + 32'h100 * i, 1, 1, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_pre_err", err, 1);
    chk("mid_pre_vld", vld, 1);
    chk("mid_rst_rdy", rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_vld", vld, 0);
    chk("mid_pend", pend, 0);
    chk("mid_err", err, 0);
    chk("mid_addr", addr, 0);
    chk("mid_len", len, 0);
    chk("mid_rdy", rdy, 1);
    @(negedge clk);
    drive(1, 32'hC000, 5, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("post_vld", vld, 1);
    chk("post_addr", addr, 32'hC000);
    chk("post_len", len, 5);
    @(negedge clk);
    #1;
    chk("post_done_vld", vld, 0);
    chk("post_pend", pend, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("post_pend_clear", pend, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
